// File: rtl/tx_sched_if.sv
// tx_sched_if: TX FIFO read port and bit-transmitter handshake bundle.
// The scheduler (master) pops the FIFO and starts frames; FIFO/transmitter side is the slave.
interface tx_sched_if;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd;
    logic       tx_rdy;
    logic [7:0] tx_din;
    logic       tx_en;

    modport master (
        input  fifo_empty, fifo_dout, tx_rdy,
        output fifo_rd, tx_din, tx_en
    );

    modport slave (
        output fifo_empty, fifo_dout, tx_rdy,
        input  fifo_rd, tx_din, tx_en
    );
endinterface

// File: rtl/tx_sched.sv
// tx_sched: drains the TX FIFO into the bit transmitter one frame at a time, with CTS flow control,
// a programmable post-frame idle gap in baud ticks, flush, start-timeout detection and a sent counter.
module tx_sched #(
    parameter int GAP_TICKS = 1,
    parameter int CTS_SYNC  = 2,
    parameter int START_TO  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bclk,
    input  logic        cts,
    input  logic        flush,
    tx_sched_if.master  bus,
    output logic        busy,
    output logic        err_start,
    output logic [15:0] sent_cnt
);
    localparam int GW = GAP_TICKS > 1 ? $clog2(GAP_TICKS) : 1;
    localparam int TW = START_TO > 1 ? $clog2(START_TO) : 1;

    typedef enum logic [2:0] {IDLE, POP, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP, DROP} state_t;

    state_t              state;
    state_t              state_nx;
    logic [CTS_SYNC-1:0] cts_sync;
    logic                cts_s;
    logic [GW-1:0]       gap_cnt;
    logic [TW-1:0]       to_cnt;
    logic                gap_last;
    logic                to_last;

    assign cts_s    = cts_sync[CTS_SYNC-1];
    assign gap_last = gap_cnt == GW'(GAP_TICKS - 1);
    assign to_last  = to_cnt == TW'(START_TO - 1);

    // Synchronise the asynchronous CTS; it resets to "not clear" so nothing leaves before the peer agrees
    always_ff @(posedge clk or negedge rst)
        if (!rst) cts_sync <= '0;
        else      cts_sync <= {cts_sync[CTS_SYNC-2:0], cts};

    // Next-state decision; flush and CTS are only looked at in IDLE so a started frame always completes
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = bus.fifo_empty ? IDLE : flush ? DROP : cts_s ? POP : IDLE;
            POP:       state_nx = LOAD;
            LOAD:      state_nx = START;
            START:     state_nx = WAIT_BUSY;
            WAIT_BUSY: state_nx = !bus.tx_rdy ? WAIT_DONE : to_last ? IDLE : WAIT_BUSY;
            WAIT_DONE: state_nx = !bus.tx_rdy ? WAIT_DONE : GAP_TICKS > 0 ? GAP : IDLE;
            GAP:       state_nx = bclk && gap_last ? IDLE : GAP;
            DROP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // State register with outputs registered from the next state, so they are pure decodes of state
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= IDLE;
            bus.fifo_rd <= 1'b0;
            bus.tx_en   <= 1'b0;
            bus.tx_din  <= 8'h00;
            busy        <= 1'b0;
            err_start   <= 1'b0;
            sent_cnt    <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
        end else begin
            state       <= state_nx;
            bus.fifo_rd <= state_nx == POP || state_nx == DROP;
            bus.tx_en   <= state_nx == START;
            busy        <= state_nx != IDLE;
            err_start   <= state == WAIT_BUSY && bus.tx_rdy && to_last;
            to_cnt      <= state == WAIT_BUSY ? to_cnt + 1'b1 : '0;
            gap_cnt     <= state == GAP ? gap_cnt + GW'(bclk) : '0;
            if (state == LOAD) bus.tx_din <= bus.fifo_dout;
            if (state == WAIT_DONE && bus.tx_rdy) sent_cnt <= sent_cnt + 1'b1;
        end
endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: random and directed stimulus for tx_sched with a FIFO/transmitter model and a scoreboard
module tb_tx_sched;
    localparam int GAP_TICKS = 2;
    localparam int CTS_SYNC  = 2;
    localparam int START_TO  = 64;

    logic        clk = 0, rst = 0, bclk = 0, cts = 0, flush = 0;
    logic        busy, err_start;
    logic [15:0] sent_cnt;

    tx_sched_if bus();

    tx_sched #(.GAP_TICKS(GAP_TICKS), .CTS_SYNC(CTS_SYNC), .START_TO(START_TO)) dut (
        .clk(clk), .rst(rst), .bclk(bclk), .cts(cts), .flush(flush), .bus(bus),
        .busy(busy), .err_start(err_start), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;

    int         compared = 0, mismatched = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         exp_sent = 0, n_err = 0;
    bit         dead = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // FIFO, transmitter and baud tick model: sample DUT at negedge, react just after posedge
    bit env_rd, env_en;
    int xs = 0, xcnt = 0, bper = 0;
    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = 8'h00;
        bus.tx_rdy     = 1'b1;
        forever begin
            @(negedge clk);
            env_rd = bus.fifo_rd;
            env_en = bus.tx_en;
            @(posedge clk);
            #1;
            if (env_rd) begin
                check(fifo_q.size() > 0, "underflow", fifo_q.size(), 1);
                if (fifo_q.size() > 0) bus.fifo_dout = fifo_q.pop_front();
            end
            if (!rst) begin
                xs = 0;
                bus.tx_rdy = 1'b1;
            end else begin
                if (xs == 1) begin
                    xcnt--;
                    if (xcnt == 0) begin bus.tx_rdy = 1'b0; xs = 2; xcnt = $urandom_range(3, 40); end
                end else if (xs == 2) begin
                    xcnt--;
                    if (xcnt == 0) begin bus.tx_rdy = 1'b1; xs = 0; exp_sent++; end
                end
                if (env_en && !dead) begin xs = 1; xcnt = $urandom_range(1, 4); end
            end
            bus.fifo_empty = fifo_q.size() == 0;
            if (bper == 0) begin bclk = 1'b1; bper = $urandom_range(2, 7); end
            else begin bclk = 1'b0; bper--; end
        end
    end

    // Monitor: checks every tx_en against the scoreboard, plus latency, gap and timeout timing
    int mcyc = 0, ticks = 1000, gap_cyc = -100, rd_cyc = -100, en_cyc = -100;
    bit prev_rdy = 1, prev_busy = 0, armed = 0;
    initial begin
        forever begin
            @(negedge clk);
            mcyc++;
            if (!rst) begin
                ticks = 1000; armed = 0; prev_rdy = 1; prev_busy = 0;
            end else begin
                if (bus.tx_rdy && !prev_rdy && busy) begin
                    ticks = 0;
                    armed = 1;
                end else if (bclk && ticks < 1000) begin
                    ticks++;
                    if (armed && ticks == GAP_TICKS) gap_cyc = mcyc;
                end
                if (prev_busy && !busy && armed) begin
                    check(mcyc == gap_cyc + 1, "gap_end", mcyc - gap_cyc, 1);
                    armed = 0;
                end
                if (bus.fifo_rd) rd_cyc = mcyc;
                if (bus.tx_en) begin
                    check(mcyc - rd_cyc == 2, "rd_to_en", mcyc - rd_cyc, 2);
                    check(ticks >= GAP_TICKS, "gap_ticks", ticks, GAP_TICKS);
                    check(exp_q.size() > 0, "unexpected_tx_en", bus.tx_din, 0);
                    if (exp_q.size() > 0) begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        check(bus.tx_din == e, "tx_din", bus.tx_din, e);
                    end
                    en_cyc = mcyc;
                end
                if (err_start) begin
                    n_err++;
                    ticks = 1000;
                    check(dead && mcyc - en_cyc == START_TO + 1, "start_timeout", mcyc - en_cyc, START_TO + 1);
                end
                prev_rdy  = bus.tx_rdy;
                prev_busy = busy;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        if (!flush) exp_q.push_back(b);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || busy) && k < 5000) begin
            tick();
            k++;
        end
        check(k < 5000, name, k, 5000);
    endtask

    // Stimulus: directed scenarios, then random traffic, timeout and reset mid-frame
    initial begin
        int n, nrd, last;
        bit bad, spacing_ok;
        tick(3);
        check(busy == 1'b0, "rst_busy", busy, 0);
        check(bus.fifo_rd == 1'b0, "rst_fifo_rd", bus.fifo_rd, 0);
        check(bus.tx_en == 1'b0, "rst_tx_en", bus.tx_en, 0);
        check(bus.tx_din == 8'h00, "rst_tx_din", bus.tx_din, 0);
        check(err_start == 1'b0, "rst_err", err_start, 0);
        check(sent_cnt == 16'h0, "rst_sent", sent_cnt, 0);
        rst = 1;
        cts = 1;
        tick(4);

        push(8'hA5);
        drain("drain_single");
        check(sent_cnt == 16'(exp_sent), "sent_single", sent_cnt, exp_sent);
        check(bus.tx_din == 8'hA5, "tx_din_hold", bus.tx_din, 8'hA5);

        push(8'h01); push(8'h02); push(8'h03);
        drain("drain_b2b");
        check(sent_cnt == 16'(exp_sent), "sent_b2b", sent_cnt, exp_sent);

        cts = 0;
        tick(5);
        for (int i = 0; i < 3; i++) push(8'($urandom));
        bad = 0;
        repeat (500) begin tick(); bad |= bus.fifo_rd | bus.tx_en | busy; end
        check(!bad, "cts_block", bad, 0);
        cts = 1;
        n = 0;
        do begin tick(); n++; end while (!bus.fifo_rd && n < 50);
        check(n == CTS_SYNC + 1, "cts_latency", n, CTS_SYNC + 1);
        cts = 0;
        n = 0;
        while ((busy || exp_q.size() != 2) && n < 2000) begin tick(); n++; end
        tick(20);
        check(fifo_q.size() == 2 && exp_q.size() == 2, "cts_midframe", fifo_q.size(), 2);
        check(sent_cnt == 16'(exp_sent), "sent_cts", sent_cnt, exp_sent);
        cts = 1;
        drain("drain_cts");
        check(sent_cnt == 16'(exp_sent), "sent_cts_drain", sent_cnt, exp_sent);

        flush = 1;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        nrd = 0; last = -10; spacing_ok = 1; n = 0;
        repeat (40) begin
            tick();
            n++;
            if (bus.fifo_rd) begin
                if (nrd > 0 && n - last != 2) spacing_ok = 0;
                last = n;
                nrd++;
            end
        end
        check(nrd == 4, "flush_pops", nrd, 4);
        check(spacing_ok, "flush_spacing", spacing_ok, 1);
        check(!busy && bus.fifo_empty, "flush_idle", busy, 0);
        check(sent_cnt == 16'(exp_sent), "sent_flush", sent_cnt, exp_sent);
        flush = 0;

        for (int i = 0; i < 40; i++) begin
            push(8'($urandom));
            tick($urandom_range(1, 30));
            if ($urandom_range(0, 4) == 0) begin
                cts = 0;
                tick($urandom_range(1, 60));
                cts = 1;
            end
        end
        drain("drain_random");
        check(sent_cnt == 16'(exp_sent), "sent_random", sent_cnt, exp_sent);

        dead = 1;
        push(8'($urandom));
        n = 0;
        while (n_err == 0 && n < 500) begin tick(); n++; end
        drain("drain_timeout");
        check(n_err == 1, "err_count", n_err, 1);
        check(sent_cnt == 16'(exp_sent), "sent_timeout", sent_cnt, exp_sent);
        dead = 0;
        push(8'h5A);
        drain("drain_after_to");
        check(sent_cnt == 16'(exp_sent), "sent_after_to", sent_cnt, exp_sent);

        push(8'h3C);
        n = 0;
        while (bus.tx_rdy && n < 500) begin tick(); n++; end
        tick();
        @(negedge clk);
        #2;
        rst = 0;
        #1;
        check(busy == 1'b0, "mid_rst_busy", busy, 0);
        check(bus.tx_din == 8'h00, "mid_rst_tx_din", bus.tx_din, 0);
        check(sent_cnt == 16'h0, "mid_rst_sent", sent_cnt, 0);
        check(!bus.tx_en && !bus.fifo_rd && !err_start, "mid_rst_strobes", bus.tx_en, 0);
        fifo_q.delete();
        exp_q.delete();
        exp_sent = 0;
        tick(2);
        rst = 1;
        bad = 0;
        repeat (20) begin tick(); bad |= busy | bus.tx_en | bus.fifo_rd; end
        check(!bad, "post_rst_idle", bad, 0);
        check(sent_cnt == 16'h0, "post_rst_sent", sent_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d mismatched so far", mismatched);
        $fatal(1, "watchdog");
    end
endmodule
